// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------
// | seg_pkg : shared FSM encoding and active-low segment patterns
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [7:0] c_all_off = 8'hFF;

  // Patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] c_seg_0     = 7'h40;
  localparam logic [6:0] c_seg_1     = 7'h79;
  localparam logic [6:0] c_seg_2     = 7'h24;
  localparam logic [6:0] c_seg_3     = 7'h30;
  localparam logic [6:0] c_seg_4     = 7'h19;
  localparam logic [6:0] c_seg_5     = 7'h12;
  localparam logic [6:0] c_seg_6     = 7'h02;
  localparam logic [6:0] c_seg_7     = 7'h78;
  localparam logic [6:0] c_seg_8     = 7'h00;
  localparam logic [6:0] c_seg_9     = 7'h10;
  localparam logic [6:0] c_seg_dash  = 7'h3F;
  localparam logic [6:0] c_seg_blank = 7'h7F;

  function automatic logic [7:0] digit_an(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// +----------------------------------------------------------------------------
// | seg_decode : 4-bit code to active-low 7-segment pattern (combinational)
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = c_seg_blank;
    case (code_i)
      4'd0:    seg_n_o = c_seg_0;
      4'd1:    seg_n_o = c_seg_1;
      4'd2:    seg_n_o = c_seg_2;
      4'd3:    seg_n_o = c_seg_3;
      4'd4:    seg_n_o = c_seg_4;
      4'd5:    seg_n_o = c_seg_5;
      4'd6:    seg_n_o = c_seg_6;
      4'd7:    seg_n_o = c_seg_7;
      4'd8:    seg_n_o = c_seg_8;
      4'd9:    seg_n_o = c_seg_9;
      4'hA:    seg_n_o = c_seg_dash;
      default: seg_n_o = c_seg_blank;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// +----------------------------------------------------------------------------
// | seg_scan_driver : 8-digit multiplexed 7-segment driver with dead-time
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYC   = 500,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic        clk_M,
  input  logic        rst_n,
  input  logic [2:0]  Bit_Sel,
  input  logic [31:0] digit_data,
  input  logic [2:0]  dp_pos,
  input  logic        load,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] c_blank_last = 16'(BLANK_CYC - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  sel_q;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] disp_q, disp_d;
  logic [2:0]  shadow_dp_q, shadow_dp_d;
  logic [2:0]  disp_dp_q, disp_dp_d;
  logic [7:0]  an_q, seg_q;
  logic        frame_q;

  logic        sel_change;
  logic        boundary;
  logic [7:0]  lead_zero;
  logic [3:0]  cur_code;
  logic        suppress;
  logic [6:0]  dec_seg;
  logic [7:0]  drive_an;
  logic [7:0]  drive_seg;

  assign sel_change = (Bit_Sel != sel_q);
  assign boundary   = (sel_q == 3'd7) && (Bit_Sel == 3'd0);

  // A load coincident with the boundary bypasses the shadow straight to display.
  always_comb begin
    shadow_d    = load ? digit_data : shadow_q;
    shadow_dp_d = load ? dp_pos : shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    if (boundary) begin
      disp_d    = load ? digit_data : shadow_q;
      disp_dp_d = load ? dp_pos : shadow_dp_q;
    end
  end

  always_comb begin
    lead_zero    = '0;
    lead_zero[7] = (disp_q[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      lead_zero[i] = lead_zero[i+1] && (disp_q[i*4 +: 4] == 4'd0);
    end
  end

  assign cur_code  = disp_q[{sel_q, 2'b00} +: 4];
  assign suppress  = LZ_SUPPRESS && lead_zero[sel_q];
  assign drive_an  = digit_an(sel_q);
  assign drive_seg = {(sel_q != disp_dp_q), dec_seg};

  seg_decode u_decode (
    .code_i  (suppress ? 4'hF : cur_code),
    .seg_n_o (dec_seg)
  );

  always_ff @(posedge clk_M or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 3'd0;
      shadow_q    <= '0;
      disp_q      <= '0;
      shadow_dp_q <= 3'd0;
      disp_dp_q   <= 3'd0;
      frame_q     <= 1'b0;
    end else begin
      sel_q       <= Bit_Sel;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      shadow_dp_q <= shadow_dp_d;
      disp_dp_q   <= disp_dp_d;
      frame_q     <= boundary;
    end
  end

  // Outputs are registered alongside the state so DRIVE data lands one
  // cycle after the counter expires.
  always_ff @(posedge clk_M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= 16'd0;
      an_q    <= c_all_off;
      seg_q   <= c_all_off;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (sel_change) begin
            state_q <= ST_BLANK;
            cnt_q   <= 16'd0;
          end
        end
        ST_BLANK: begin
          if (sel_change) begin
            cnt_q <= 16'd0;
          end else if (cnt_q == c_blank_last) begin
            state_q <= ST_DRIVE;
            an_q    <= drive_an;
            seg_q   <= drive_seg;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (sel_change) begin
            state_q <= ST_BLANK;
            cnt_q   <= 16'd0;
            an_q    <= c_all_off;
            seg_q   <= c_all_off;
          end else begin
            an_q  <= drive_an;
            seg_q <= drive_seg;
          end
        end
        default: begin
          state_q <= ST_OFF;
          an_q    <= c_all_off;
          seg_q   <= c_all_off;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// +----------------------------------------------------------------------------
// | tb_seg_scan_driver : scoreboard bench, two configurations vs behavioural model
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  localparam int BC0 = 4;
  localparam int BC1 = 1;

  logic        clk_M = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  Bit_Sel = 3'd0;
  logic [31:0] digit_data = 32'd0;
  logic [2:0]  dp_pos = 3'd0;
  logic        load = 1'b0;
  logic [7:0]  an0, seg0, an1, seg1;
  logic        fd0, fd1;

  always #5 clk_M = ~clk_M;

  seg_scan_driver #(.BLANK_CYC(BC0), .LZ_SUPPRESS(1'b1)) dut0 (
    .clk_M(clk_M), .rst_n(rst_n), .Bit_Sel(Bit_Sel), .digit_data(digit_data),
    .dp_pos(dp_pos), .load(load), .an(an0), .seg(seg0), .frame_done(fd0)
  );

  seg_scan_driver #(.BLANK_CYC(BC1), .LZ_SUPPRESS(1'b0)) dut1 (
    .clk_M(clk_M), .rst_n(rst_n), .Bit_Sel(Bit_Sel), .digit_data(digit_data),
    .dp_pos(dp_pos), .load(load), .an(an1), .seg(seg1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Behavioural model: what the display should show, in terms of how long
  // the select has been stable and what the frame-latched digits are.
  logic [2:0] m_sel;
  logic [3:0] m_disp[8];
  logic [3:0] m_shad[8];
  logic [2:0] m_disp_dp, m_shad_dp;
  int         m_age;
  bit         m_started;
  logic [6:0] pat[11];  // active-high {g,f,e,d,c,b,a}

  initial begin
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
    pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
    pat[8] = 7'h7F; pat[9] = 7'h6F; pat[10] = 7'h40;
  end

  task automatic model_reset();
    m_sel = 3'd0; m_age = 0; m_started = 1'b0;
    m_disp_dp = 3'd0; m_shad_dp = 3'd0;
    for (int i = 0; i < 8; i++) begin
      m_disp[i] = 4'd0;
      m_shad[i] = 4'd0;
    end
  endtask

  function automatic exp_t predict(input int bc, input bit lz);
    exp_t       e;
    int         d;
    int         msd;
    logic [3:0] code;
    logic [6:0] p;
    e.an = 8'hFF; e.seg = 8'hFF; e.fd = 1'b0;
    if (m_started && m_age >= bc) begin
      d = int'(m_sel);
      e.an[d] = 1'b0;
      msd = 0;
      for (int i = 0; i < 8; i++) if (m_disp[i] != 4'd0) msd = i;
      code = m_disp[d];
      if (lz && d > msd)      p = 7'h00;
      else if (code <= 4'd10) p = pat[code];
      else                    p = 7'h00;
      e.seg = {(d != int'(m_disp_dp)), ~p};
    end
    return e;
  endfunction

  task automatic step(input logic [2:0] bs, input bit ld, input logic [31:0] data, input logic [2:0] dp);
    exp_t e0, e1;
    bit   bnd;
    @(negedge clk_M);
    Bit_Sel = bs; load = ld; digit_data = data; dp_pos = dp;
    if (bs != m_sel) begin
      m_started = 1'b1;
      m_age = 0;
    end else if (m_age < 1000000) begin
      m_age++;
    end
    e0 = predict(BC0, 1'b1);
    e1 = predict(BC1, 1'b0);
    bnd = (m_sel == 3'd7) && (bs == 3'd0);
    e0.fd = bnd; e1.fd = bnd;
    q0.push_back(e0);
    q1.push_back(e1);
    if (bnd) begin
      for (int i = 0; i < 8; i++) m_disp[i] = ld ? data[4*i +: 4] : m_shad[i];
      m_disp_dp = ld ? dp : m_shad_dp;
    end
    if (ld) begin
      for (int i = 0; i < 8; i++) m_shad[i] = data[4*i +: 4];
      m_shad_dp = dp;
    end
    m_sel = bs;
  endtask

  task automatic dwell(input logic [2:0] bs, input int n);
    for (int k = 0; k < n; k++) step(bs, 1'b0, 32'd0, 3'd0);
  endtask

  task automatic scan(input int from, input int to, input int n);
    for (int s = from; s <= to; s++) dwell(3'(s), n);
  endtask

  task automatic chk_off(input string name);
    total++;
    if ({an0, seg0, fd0, an1, seg1, fd1} !== {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0}) begin
      bad++;
      $display("FAIL %s t=%0t got an0=%h seg0=%h fd0=%b an1=%h seg1=%h fd1=%b want an=ff seg=ff fd=0",
               name, $time, an0, seg0, fd0, an1, seg1, fd1);
    end
  endtask

  always @(posedge clk_M) begin
    exp_t e0, e1;
    #1;
    if (mon_en && q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      total++;
      if ({an0, seg0, fd0} !== e0) begin
        bad++;
        $display("FAIL out_cfg0 t=%0t got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 $time, an0, seg0, fd0, e0.an, e0.seg, e0.fd);
      end
      total++;
      if ({an1, seg1, fd1} !== e1) begin
        bad++;
        $display("FAIL out_cfg1 t=%0t got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 $time, an1, seg1, fd1, e1.an, e1.seg, e1.fd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  nsel;
    logic [31:0] rdata;
    int          len;
    model_reset();
    repeat (3) @(negedge clk_M);
    chk_off("reset_state");
    @(negedge clk_M);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Dead time then digit 1
    dwell(3'd0, 3);
    dwell(3'd1, 8);

    // Leading-zero blanking on 0000_0305 with dp on digit 2
    step(3'd1, 1'b1, 32'h0000_0305, 3'd2);
    dwell(3'd1, 2);
    scan(2, 7, 6);
    dwell(3'd0, 6);
    scan(1, 7, 6);
    dwell(3'd0, 6);

    // Mid-frame load held in shadow until the wrap
    scan(1, 2, 6);
    dwell(3'd3, 2);
    step(3'd3, 1'b1, 32'h1234_5678, 3'd5);
    dwell(3'd3, 5);
    scan(4, 7, 6);
    dwell(3'd0, 6);
    scan(1, 7, 6);

    // Last write wins
    dwell(3'd0, 6);
    step(3'd2, 1'b1, 32'hDEAD_0001, 3'd1);
    dwell(3'd2, 5);
    step(3'd4, 1'b1, 32'h0000_4321, 3'd3);
    dwell(3'd4, 5);
    scan(5, 7, 6);
    scan(0, 7, 6);

    // Load coincident with the boundary
    step(3'd0, 1'b1, 32'h00A0_9B07, 3'd0);
    dwell(3'd0, 6);
    scan(1, 2, 6);

    // Rapid re-selection restarts the dead time
    dwell(3'd3, 2);
    dwell(3'd4, 8);

    // Asynchronous reset while driving
    @(posedge clk_M);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_off("async_reset_immediate");
    q0.delete(); q1.delete();
    @(negedge clk_M);
    Bit_Sel = 3'd0; load = 1'b0;
    repeat (2) begin
      @(negedge clk_M);
      chk_off("reset_hold");
    end
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    dwell(3'd0, 5);
    dwell(3'd6, 7);

    // Randomised scanning with occasional loads
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) nsel = 3'($urandom_range(0, 7));
      else                           nsel = m_sel + 3'd1;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          rdata = $urandom >> (4 * $urandom_range(0, 7));
          step(nsel, 1'b1, rdata, 3'($urandom_range(0, 7)));
        end else begin
          step(nsel, 1'b0, 32'd0, 3'd0);
        end
      end
    end

    @(posedge clk_M);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 500, dead-time clock cycles with all digits off after each select change (range 1..65535).
REQ-002 SHALL have parameter LZ_SUPPRESS, default 1, which enables leading-zero blanking when set to 1.
REQ-003 SHALL have port clk_M, input, 1 bit: the single system clock, 50 MHz; all logic is rising-edge on clk_M.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port Bit_Sel, input, 3 bits: digit index from the refresh divider, synchronous to clk_M.
REQ-006 SHALL have port digit_data, input, 32 bits: eight 4-bit codes, where [3:0] is digit 0 (least significant) and [31:28] is digit 7.
REQ-007 SHALL have port dp_pos, input, 3 bits: index of the digit whose decimal point is lit.
REQ-008 SHALL have port load, input, 1 bit: single-cycle strobe that captures digit_data and dp_pos into the shadow register.
REQ-009 SHALL have port an, output, 8 bits: digit enables, active-low, one-hot-low when driving.
REQ-010 SHALL have port seg, output, 8 bits: segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse on each frame boundary.

Function
REQ-012 SHALL register Bit_Sel into sel_q every cycle; a select change is defined as Bit_Sel != sel_q.
REQ-013 SHALL implement an FSM with states OFF (reset), BLANK and DRIVE.
REQ-014 SHALL apply these transitions:
- OFF->BLANK on the first select change.
- DRIVE->BLANK on any select change.
- BLANK->BLANK (counter reload) on a select change during BLANK.
- BLANK->DRIVE when the counter reaches BLANK_CYC-1 with no change.
REQ-015 SHALL, in OFF and BLANK, drive an=8'hFF and seg=8'hFF.
REQ-016 SHALL, in DRIVE, drive an=~(8'b1<<sel_q) and seg from the decode of display digit sel_q.
REQ-017 SHALL register an and seg, so the first DRIVE output appears exactly BLANK_CYC+1 cycles after the cycle in which the change was detected.
REQ-018 SHALL decode codes 0-9 as standard digits, 0xA as '-' (g only), and 0xB-0xF as blank.
REQ-019 SHALL light dp (seg[7]=0) only when sel_q==display dp_pos.
REQ-020 SHALL, with LZ_SUPPRESS=1, blank digit i (i=7..1) when digits 7..i of the display register are all zero; digit 0 is never suppressed.
REQ-021 SHALL transfer the shadow register into the display register only on a frame boundary, defined as sel_q==7 and Bit_Sel==0.
REQ-022 SHALL, when load and a frame boundary occur in the same cycle, write the new digit_data/dp_pos directly into both the shadow and display registers.
REQ-023 SHALL, when load repeats before a boundary, keep only the last value (last write wins).
REQ-024 SHALL pulse frame_done for exactly one cycle, in the cycle after the boundary is detected.
REQ-025 SHALL treat non-sequential select jumps like any other change (blank, then drive the new index); wrap 7->0 is also a frame boundary.

Reset
REQ-026 SHALL, with rst_n low, asynchronously force:
- state OFF, an=8'hFF, seg=8'hFF, frame_done=0;
- sel_q=0, blank counter=0;
- shadow and display registers=0, dp_pos=0.
REQ-027 SHALL, on rst_n asserted mid-DRIVE, turn all digits off in the same instant without waiting for a clock edge.
REQ-028 SHALL synchronise reset release externally; the first change after release enters BLANK normally.

Structure
REQ-029 SHALL place the FSM state encoding, segment patterns for 0-9/'-'/blank, and the all-off constant 8'hFF in a shared package seg_pkg.
REQ-030 SHALL implement the BCD-to-segment decode as a combinational sub-module seg_decode (4-bit code in, 7-bit active-low out).
REQ-031 SHALL size the blank counter at 16 bits.

Verification
REQ-032 SHALL cover: BLANK_CYC=4, Bit_Sel 0->1 -> an=8'hFF for 5 cycles, then an=8'hFD with seg set to the digit 1 pattern.
REQ-033 SHALL cover: digit_data=32'h0000_0305, LZ=1 -> digits 7..3 blank, digit 2 shows 3, digit 1 shows 0, digit 0 shows 5.
REQ-034 SHALL cover: load 32'h1234_5678 at sel 3 -> old value shown until the 7->0 boundary, new value after, frame_done pulse of 1 cycle.
REQ-035 SHALL cover: load coincident with the boundary -> new value on digit 0 of the same frame.
REQ-036 SHALL cover: Bit_Sel changes 2->3->4 within one blank window -> counter restarts, only an=8'hEF is ever driven.
REQ-037 SHALL cover: rst_n low mid-DRIVE -> an/seg go to 8'hFF before the next clk_M edge and stay until a change after release.
